// File: rtl/timer_irq_ctrl.sv
// ----------------------------------------------------------------------------
// timer_irq_ctrl
//
// Status and interrupt stage that sits directly downstream of the timer
// counter. It watches the counter value against two compare registers,
// counts overflow events, keeps sticky write-1-to-clear status flags and
// drives one registered, maskable interrupt line.
//
// Flag / mask / clear bit map (status, irq_mask, clr):
//   bit0 overflow, bit1 compare channel 0, bit2 compare channel 1
//
// Ports:
//   clk           in   block clock, shared with the counter
//   rst_n         in   synchronous, active-low reset
//   value         in   current counter value            [COUNTER_SIZE]
//   overflow_set  in   overflow indication, one event per high cycle
//   cmp0, cmp1    in   compare values                    [COUNTER_SIZE]
//   irq_mask      in   interrupt enables                 [3]
//   clr           in   write-1-to-clear strobes          [3]
//   status        out  sticky flags                      [3]
//   ovf_count     out  saturating overflow event count   [OVF_CNT_SIZE]
//   ovf_lost      out  sticky: overflow while status[0] already set
//   match0/1      out  one-cycle compare-match pulses
//   irq           out  registered interrupt request
//
// There are no handshakes: every input is sampled on each rising edge and
// every output is a flop updated on that same edge.
// ----------------------------------------------------------------------------
module timer_irq_ctrl #(
    parameter int COUNTER_SIZE = 8,
    parameter int OVF_CNT_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [COUNTER_SIZE-1:0] value,
    input  logic                    overflow_set,
    input  logic [COUNTER_SIZE-1:0] cmp0,
    input  logic [COUNTER_SIZE-1:0] cmp1,
    input  logic [2:0]              irq_mask,
    input  logic [2:0]              clr,
    output logic [2:0]              status,
    output logic [OVF_CNT_SIZE-1:0] ovf_count,
    output logic                    ovf_lost,
    output logic                    match0,
    output logic                    match1,
    output logic                    irq
);

    localparam logic [OVF_CNT_SIZE-1:0] CNT_MAX = '1;
    localparam logic [OVF_CNT_SIZE-1:0] CNT_ONE = OVF_CNT_SIZE'(1);

    logic                    r_eq0_d;
    logic                    r_eq1_d;
    logic [2:0]              r_status;
    logic [OVF_CNT_SIZE-1:0] r_ovf_count;
    logic                    r_ovf_lost;
    logic                    r_match0;
    logic                    r_match1;
    logic                    r_irq;

    logic                    w_eq0;
    logic                    w_eq1;
    logic                    w_ev0;
    logic                    w_ev1;
    logic                    w_evo;
    logic [2:0]              w_ev;
    logic [2:0]              w_status_next;
    logic [OVF_CNT_SIZE-1:0] w_count_next;
    logic                    w_lost_next;

    // Rising-edge detection on equality: a counter parked on the compare
    // value yields a single event, and a compare-register write that makes
    // equality true also yields one.
    assign w_eq0 = (value == cmp0);
    assign w_eq1 = (value == cmp1);
    assign w_ev0 = w_eq0 & ~r_eq0_d;
    assign w_ev1 = w_eq1 & ~r_eq1_d;

    // Overflow is a level: every high cycle is its own event.
    assign w_evo = overflow_set;
    assign w_ev  = {w_ev1, w_ev0, w_evo};

    // Set wins over clear so an event coinciding with its clear survives.
    assign w_status_next = (r_status & ~clr) | w_ev;

    always_comb begin
        w_count_next = r_ovf_count;
        if (clr[0]) begin
            // A clear together with an event restarts the count at one.
            w_count_next = w_evo ? CNT_ONE : '0;
        end else if (w_evo && (r_ovf_count != CNT_MAX)) begin
            w_count_next = r_ovf_count + CNT_ONE;
        end
    end

    always_comb begin
        w_lost_next = r_ovf_lost;
        if (w_evo && r_status[0] && !clr[0]) begin
            w_lost_next = 1'b1;
        end else if (clr[0]) begin
            w_lost_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_eq0_d     <= 1'b0;
            r_eq1_d     <= 1'b0;
            r_status    <= 3'b000;
            r_ovf_count <= '0;
            r_ovf_lost  <= 1'b0;
            r_match0    <= 1'b0;
            r_match1    <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_eq0_d     <= w_eq0;
            r_eq1_d     <= w_eq1;
            r_status    <= w_status_next;
            r_ovf_count <= w_count_next;
            r_ovf_lost  <= w_lost_next;
            r_match0    <= w_ev0;
            r_match1    <= w_ev1;
            // Built from the next flag state so irq tracks status on the
            // same edge instead of lagging it by a cycle.
            r_irq       <= |(w_status_next & irq_mask);
        end
    end

    assign status    = r_status;
    assign ovf_count = r_ovf_count;
    assign ovf_lost  = r_ovf_lost;
    assign match0    = r_match0;
    assign match1    = r_match1;
    assign irq       = r_irq;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_timer_irq_ctrl
//
// Self-checking bench for timer_irq_ctrl. A table of {inputs, expected
// outputs} records is applied one per clock; hand-written loops cover the
// overflow saturation and mid-operation reset sequences. Expected output
// words are queued when stimulus is driven and popped when the DUT output
// is sampled, 1 time unit after the rising edge.
//
// Output word layout: {status[2:0], ovf_count[3:0], ovf_lost, match0,
// match1, irq}.
// ----------------------------------------------------------------------------
module tb_timer_irq_ctrl;

    localparam int CW = 8;
    localparam int OW = 4;
    localparam int NV = 28;

    typedef struct {
        logic          rst_n;
        logic [CW-1:0] value;
        logic          ovf;
        logic [CW-1:0] cmp0;
        logic [CW-1:0] cmp1;
        logic [2:0]    mask;
        logic [2:0]    clr;
        logic [10:0]   exp;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic [CW-1:0] value = '0;
    logic          overflow_set = 1'b0;
    logic [CW-1:0] cmp0 = '0;
    logic [CW-1:0] cmp1 = '0;
    logic [2:0]    irq_mask = '0;
    logic [2:0]    clr = '0;
    logic [2:0]    status;
    logic [OW-1:0] ovf_count;
    logic          ovf_lost;
    logic          match0;
    logic          match1;
    logic          irq;

    timer_irq_ctrl #(.COUNTER_SIZE(CW), .OVF_CNT_SIZE(OW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .value        (value),
        .overflow_set (overflow_set),
        .cmp0         (cmp0),
        .cmp1         (cmp1),
        .irq_mask     (irq_mask),
        .clr          (clr),
        .status       (status),
        .ovf_count    (ovf_count),
        .ovf_lost     (ovf_lost),
        .match0       (match0),
        .match1       (match1),
        .irq          (irq)
    );

    // scoreboard
    logic [10:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    vec_t tbl[NV];

    function automatic logic [10:0] pk(input logic [2:0] st, input int cnt,
                                       input logic lost, input logic m0,
                                       input logic m1, input logic iq);
        logic [OW-1:0] c;
        c = OW'(cnt);
        return {st, c, lost, m0, m1, iq};
    endfunction

    function automatic vec_t mk(input logic r, input int v, input logic o,
                                input int c0, input int c1,
                                input logic [2:0] m, input logic [2:0] c,
                                input logic [10:0] e);
        vec_t t;
        t.rst_n = r;
        t.value = CW'(v);
        t.ovf   = o;
        t.cmp0  = CW'(c0);
        t.cmp1  = CW'(c1);
        t.mask  = m;
        t.clr   = c;
        t.exp   = e;
        return t;
    endfunction

    // driver: drive on the falling edge, queue the expectation, then sample
    // just after the next rising edge and compare.
    task automatic apply(input vec_t t, input string name);
        logic [10:0] got;
        logic [10:0] want;
        @(negedge clk);
        rst_n        = t.rst_n;
        value        = t.value;
        overflow_set = t.ovf;
        cmp0         = t.cmp0;
        cmp1         = t.cmp1;
        irq_mask     = t.mask;
        clr          = t.clr;
        exp_q.push_back(t.exp);
        @(posedge clk);
        #1;
        got  = {status, ovf_count, ovf_lost, match0, match1, irq};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: scoreboard empty, got=%b", name, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_errors++;
                $display("FAIL %s: got st=%b cnt=%0d lost=%b m0=%b m1=%b irq=%b, want st=%b cnt=%0d lost=%b m0=%b m1=%b irq=%b",
                         name, got[10:8], got[7:4], got[3], got[2], got[1], got[0],
                         want[10:8], want[7:4], want[3], want[2], want[1], want[0]);
            end
        end
    endtask

    initial begin
        int   cnt;
        vec_t t;

        // rst, value, ovf, cmp0, cmp1, mask, clr, expected {st,cnt,lost,m0,m1,irq}
        tbl[0]  = mk(0,   5, 1,  5, 200, 3'b000, 3'b000, pk(3'b000, 0, 0, 0, 0, 0));
        tbl[1]  = mk(0,   5, 1,  5, 200, 3'b000, 3'b000, pk(3'b000, 0, 0, 0, 0, 0));
        tbl[2]  = mk(1,   5, 1,  5, 200, 3'b000, 3'b000, pk(3'b011, 1, 0, 1, 0, 0));
        tbl[3]  = mk(1,   5, 0,  5, 200, 3'b000, 3'b000, pk(3'b011, 1, 0, 0, 0, 0));
        tbl[4]  = mk(1,   7, 0,  8, 200, 3'b000, 3'b111, pk(3'b000, 0, 0, 0, 0, 0));
        tbl[5]  = mk(1,   7, 0,  8, 200, 3'b000, 3'b000, pk(3'b000, 0, 0, 0, 0, 0));
        tbl[6]  = mk(1,   8, 0,  8, 200, 3'b000, 3'b000, pk(3'b010, 0, 0, 1, 0, 0));
        tbl[7]  = mk(1,   8, 0,  8, 200, 3'b000, 3'b000, pk(3'b010, 0, 0, 0, 0, 0));
        tbl[8]  = mk(1,   8, 0,  8, 200, 3'b000, 3'b000, pk(3'b010, 0, 0, 0, 0, 0));
        tbl[9]  = mk(1,   9, 0,  8, 200, 3'b000, 3'b000, pk(3'b010, 0, 0, 0, 0, 0));
        tbl[10] = mk(1,   9, 0,  8, 200, 3'b000, 3'b010, pk(3'b000, 0, 0, 0, 0, 0));
        tbl[11] = mk(1,   8, 0,  8, 200, 3'b000, 3'b000, pk(3'b010, 0, 0, 1, 0, 0));
        tbl[12] = mk(1,   9, 0,  8, 200, 3'b000, 3'b000, pk(3'b010, 0, 0, 0, 0, 0));
        tbl[13] = mk(1,   8, 0,  8, 200, 3'b000, 3'b010, pk(3'b010, 0, 0, 1, 0, 0));
        tbl[14] = mk(1,   9, 0,  8, 200, 3'b000, 3'b010, pk(3'b000, 0, 0, 0, 0, 0));
        tbl[15] = mk(1,  19, 0, 20,  20, 3'b000, 3'b000, pk(3'b000, 0, 0, 0, 0, 0));
        tbl[16] = mk(1,  20, 0, 20,  20, 3'b000, 3'b000, pk(3'b110, 0, 0, 1, 1, 0));
        tbl[17] = mk(1,  21, 0, 20,  20, 3'b001, 3'b000, pk(3'b110, 0, 0, 0, 0, 0));
        tbl[18] = mk(1,  21, 0, 20,  20, 3'b100, 3'b000, pk(3'b110, 0, 0, 0, 0, 1));
        tbl[19] = mk(1,  21, 0, 20,  20, 3'b100, 3'b100, pk(3'b010, 0, 0, 0, 0, 0));
        tbl[20] = mk(1,  21, 0, 20,  20, 3'b010, 3'b000, pk(3'b010, 0, 0, 0, 0, 1));
        tbl[21] = mk(1,  21, 0, 20,  20, 3'b010, 3'b010, pk(3'b000, 0, 0, 0, 0, 0));
        tbl[22] = mk(1,  21, 0, 30, 200, 3'b000, 3'b000, pk(3'b000, 0, 0, 0, 0, 0));
        tbl[23] = mk(1,  21, 0, 21, 200, 3'b000, 3'b000, pk(3'b010, 0, 0, 1, 0, 0));
        tbl[24] = mk(1,  21, 0, 30, 200, 3'b000, 3'b010, pk(3'b000, 0, 0, 0, 0, 0));
        tbl[25] = mk(1, 255, 0, 30, 255, 3'b000, 3'b000, pk(3'b100, 0, 0, 0, 1, 0));
        tbl[26] = mk(1, 255, 0, 30, 255, 3'b000, 3'b100, pk(3'b000, 0, 0, 0, 0, 0));
        tbl[27] = mk(1, 127, 0, 30, 255, 3'b000, 3'b000, pk(3'b000, 0, 0, 0, 0, 0));

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // 20 single-cycle overflow pulses: count saturates at 15, lost from
        // the second pulse on.
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            if (cnt < 15) cnt++;
            t = mk(1, 127, 1, 30, 200, 3'b000, 3'b000,
                   pk(3'b001, cnt, (i >= 2), 0, 0, 0));
            apply(t, $sformatf("ovf_pulse%0d", i));
            t = mk(1, 127, 0, 30, 200, 3'b000, 3'b000,
                   pk(3'b001, cnt, (i >= 2), 0, 0, 0));
            apply(t, $sformatf("ovf_idle%0d", i));
        end

        // Clear together with a pulse restarts the count at 1.
        apply(mk(1, 127, 1, 30, 200, 3'b000, 3'b001, pk(3'b001, 1, 0, 0, 0, 0)), "ovf_clr_pulse");
        apply(mk(1, 127, 0, 30, 200, 3'b000, 3'b001, pk(3'b000, 0, 0, 0, 0, 0)), "ovf_clr_only");

        // Build status=111, count=9, irq=1, then reset for one cycle.
        apply(mk(1, 127, 0, 40, 40, 3'b111, 3'b111, pk(3'b000, 0, 0, 0, 0, 0)), "mid_prep");
        for (int i = 1; i <= 9; i++) begin
            if (i < 9)
                t = mk(1, 127, 1, 40, 40, 3'b111, 3'b000, pk(3'b001, i, (i >= 2), 0, 0, 1));
            else
                t = mk(1,  40, 1, 40, 40, 3'b111, 3'b000, pk(3'b111, i, 1, 1, 1, 1));
            apply(t, $sformatf("mid_fill%0d", i));
        end
        apply(mk(0, 41, 1, 40, 40, 3'b111, 3'b000, pk(3'b000, 0, 0, 0, 0, 0)), "mid_reset");
        apply(mk(1, 41, 1, 40, 40, 3'b111, 3'b000, pk(3'b001, 1, 0, 0, 0, 1)), "mid_restart");
        apply(mk(1, 41, 1, 40, 40, 3'b111, 3'b000, pk(3'b001, 2, 1, 0, 0, 1)), "mid_count2");

        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover: got %0d queued entries, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety net: the sequence is clock-driven, so this only fires if the
    // simulation stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
